proj_fm_feeder: RTL

- Write-side producer for the fragment memory (FM) double buffer.
- Accepts packed input words over a valid/ready stream and unpacks them into DATA_BITS symbols.
- Drives the FM write data and buffer-swap request in lockstep with the FM's free-running write address.
- The FM has no write-valid and never stalls mid-fill, so this block stages a complete buffer before each swap. It also tells the downstream fragment reader whether the published read buffer holds real data.

---
 rtl/proj_fm_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/proj_fm_feeder.sv
// Write-side feeder for the fragment-memory double buffer: unpacks stream words into
// DATA_BITS symbols and drives FM write data and swap requests in step with the FM address.
`timescale 1ns/1ps
module proj_fm_feeder #(
  parameter int DATA_BITS      = 2,
  parameter int FM_BUFFER_SIZE = 32,
  parameter int IN_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic                 fm_wait,
  input  logic                 swap_ok,
  output logic [DATA_BITS-1:0] fm_wdata,
  output logic                 fm_chg_idx,
  output logic                 rd_buf_valid,
  output logic                 rd_buf_last,
  output logic                 sync_err
);

  localparam int WORDS        = FM_BUFFER_SIZE * DATA_BITS / IN_WIDTH;
  localparam int WCNT_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W        = (FM_BUFFER_SIZE > 1) ? $clog2(FM_BUFFER_SIZE) : 1;
  localparam int SYM_PER_WORD = IN_WIDTH / DATA_BITS;

  localparam logic [WCNT_W-1:0] WCNT_LAST    = WCNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE_TAIL = CNT_W'(FM_BUFFER_SIZE - 2);

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_SWAP   = 1'b1;

  logic [IN_WIDTH-1:0]  stg_word [WORDS];
  logic [WCNT_W-1:0]    wcnt;
  logic                 stg_full;
  logic                 stg_last;

  logic [IN_WIDTH-1:0]  act_word [WORDS];
  logic                 act_valid;
  logic                 act_last;
  logic [DATA_BITS-1:0] act_sym  [FM_BUFFER_SIZE];

  logic [CNT_W-1:0]     cnt;
  logic                 drain;
  logic [0:0]           state;

  logic                 accept;
  logic                 fire;

  for (genvar k = 0; k < FM_BUFFER_SIZE; k++) begin : g_sym
    assign act_sym[k] = act_word[k / SYM_PER_WORD][(k % SYM_PER_WORD) * DATA_BITS +: DATA_BITS];
  end

  assign s_ready    = ~stg_full;
  assign accept     = s_valid & s_ready;
  assign fire       = (state == ST_SWAP) & fm_wait & swap_ok & (stg_full | drain);
  assign fm_chg_idx = fire;
  // cnt parks at the tail index while in SWAP, so one select covers both states
  assign fm_wdata   = act_sym[cnt];

  // Staging loader: fills one buffer's worth of words, zero-filling after an early s_last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt     <= '0;
      stg_full <= 1'b0;
      stg_last <= 1'b0;
      for (int i = 0; i < WORDS; i++) stg_word[i] <= '0;
    end else if (fire && stg_full) begin
      stg_full <= 1'b0;
      stg_last <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < WORDS; i++) begin
        if (WCNT_W'(i) == wcnt)
          stg_word[i] <= s_data;
        else if (s_last && (WCNT_W'(i) > wcnt))
          stg_word[i] <= '0;
      end
      if (s_last || (wcnt == WCNT_LAST)) begin
        stg_full <= 1'b1;
        stg_last <= s_last;
        wcnt     <= '0;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Stream/swap sequencer: follows the FM write address and hands staging over on a swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_STREAM;
      cnt          <= '0;
      drain        <= 1'b0;
      act_valid    <= 1'b0;
      act_last     <= 1'b0;
      rd_buf_valid <= 1'b0;
      rd_buf_last  <= 1'b0;
      sync_err     <= 1'b0;
      for (int i = 0; i < WORDS; i++) act_word[i] <= '0;
    end else begin
      if (((state == ST_STREAM) && fm_wait) || ((state == ST_SWAP) && !fm_wait))
        sync_err <= 1'b1;

      case (state)
        ST_STREAM: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_PRE_TAIL) state <= ST_SWAP;
        end
        ST_SWAP: begin
          if (fire) begin
            rd_buf_valid <= act_valid;
            rd_buf_last  <= act_last;
            if (stg_full) begin
              act_word  <= stg_word;
              act_valid <= 1'b1;
              act_last  <= stg_last;
              drain     <= stg_last;
            end else begin
              for (int i = 0; i < WORDS; i++) act_word[i] <= '0;
              act_valid <= 1'b0;
              act_last  <= 1'b0;
              drain     <= 1'b0;
            end
            cnt   <= '0;
            state <= ST_STREAM;
          end
        end
        default: begin
          state <= ST_STREAM;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
